alu_share_arbiter: RTL and testbench

//  Shares one combinational 64-bit ALU between two requesters (e.g. EX stage and a branch/address unit).
//  Per cycle, grants at most one requester, drives its operands/op to the ALU, and captures the outputs into that requester's one-entry response buffer.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Each requester owns a one-entry response buffer with valid/ready drain.
module alu_share_arbiter #(
  parameter int W          = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  input  logic [7:0]     req_op,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [2*W-1:0] rsp_result,
  output logic [1:0]     rsp_zero,
  output logic [1:0]     rsp_greater,
  output logic [1:0]     rsp_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_zero,
  input  logic           alu_greater
);

  function automatic logic legal_op(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b1100, 4'b0111: legal_op = 1'b1;
      default:                   legal_op = 1'b0;
    endcase
  endfunction

  logic              ptr;
  logic [1:0]        elig;
  logic [1:0]        grant;
  logic [3:0]        sel_op;
  logic              sel_legal;
  logic [1:0][W-1:0] res_q;
  logic [1:0]        vld_q;
  logic [1:0]        zero_q;
  logic [1:0]        gt_q;
  logic [1:0]        err_q;

  // A full buffer may still accept when it drains in the same cycle.
  assign elig = req_valid & (~vld_q | rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (elig == 2'b11)
        grant = (FIXED_PRIO || !ptr) ? 2'b01 : 2'b10;
      else
        grant = elig;
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_op = 4'b0000;
    alu_a  = '0;
    alu_b  = '0;
    unique case (1'b1)
      grant[0]: begin
        sel_op = req_op[3:0];
        alu_a  = req_a[W-1:0];
        alu_b  = req_b[W-1:0];
      end
      grant[1]: begin
        sel_op = req_op[7:4];
        alu_a  = req_a[2*W-1:W];
        alu_b  = req_b[2*W-1:W];
      end
      default: begin
        sel_op = 4'b0000;
        alu_a  = '0;
        alu_b  = '0;
      end
    endcase
  end

  assign sel_legal = legal_op(sel_op);
  assign alu_op    = sel_legal ? sel_op : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (|grant)
      ptr <= grant[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      res_q  <= '0;
      zero_q <= '0;
      gt_q   <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          vld_q[i] <= 1'b1;
          if (sel_legal) begin
            res_q[i]  <= alu_result;
            zero_q[i] <= alu_zero;
            gt_q[i]   <= alu_greater;
            err_q[i]  <= 1'b0;
          end else begin
            res_q[i]  <= '0;
            zero_q[i] <= 1'b1;
            gt_q[i]   <= 1'b0;
            err_q[i]  <= 1'b1;
          end
        end else if (rsp_ready[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid   = vld_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_greater = gt_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority instances share stimulus.
// A bench ALU model feeds each instance; expected responses are queued per requester.
module tb_alu_share_arbiter;
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         g;
    logic         e;
  } exp_t;

  function automatic exp_t ref_alu(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    exp_t r;
    r.e = 1'b0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b0010: r.res = a + b;
      4'b0110: r.res = a - b;
      4'b1100: r.res = ~(a | b);
      4'b0111: r.res = a << b[5:0];
      default: begin
        r.res = '0;
        r.e   = 1'b1;
      end
    endcase
    r.z = (r.res == '0);
    r.g = r.e ? 1'b0 : (a > b);
    return r;
  endfunction

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]   rv, rr;
  logic [W-1:0] a0, a1, b0, b1;
  logic [3:0]   op0, op1;
  logic [2*W-1:0] req_a, req_b;
  logic [7:0]     req_op;
  assign req_a  = {a1, a0};
  assign req_b  = {b1, b0};
  assign req_op = {op1, op0};

  logic [1:0]     rr_ready, rr_rsp_valid, rr_zero, rr_gt, rr_err;
  logic [2*W-1:0] rr_rsp_result;
  logic [W-1:0]   rr_alu_a, rr_alu_b;
  logic [3:0]     rr_alu_op;
  exp_t           rr_alu;
  assign rr_alu = ref_alu(rr_alu_op, rr_alu_a, rr_alu_b);

  logic [1:0]     fp_ready, fp_rsp_valid, fp_zero, fp_gt, fp_err;
  logic [2*W-1:0] fp_rsp_result;
  logic [W-1:0]   fp_alu_a, fp_alu_b;
  logic [3:0]     fp_alu_op;
  exp_t           fp_alu;
  assign fp_alu = ref_alu(fp_alu_op, fp_alu_a, fp_alu_b);

  alu_share_arbiter #(.W(W), .FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .req_valid(rv), .req_ready(rr_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rr),
    .rsp_result(rr_rsp_result), .rsp_zero(rr_zero),
    .rsp_greater(rr_gt), .rsp_err(rr_err),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
    .alu_result(rr_alu.res), .alu_zero(rr_alu.z),
    .alu_greater(rr_alu.g)
  );

  alu_share_arbiter #(.W(W), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .req_valid(rv), .req_ready(fp_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rr),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_zero),
    .rsp_greater(fp_gt), .rsp_err(fp_err),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
    .alu_result(fp_alu.res), .alu_zero(fp_alu.z),
    .alu_greater(fp_alu.g)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [1:0] mv [2];
  logic       mptr [2];
  exp_t       q0 [$];
  exp_t       q1 [$];
  bit         started = 1'b0;

  task automatic chk_rsp(input int i);
    exp_t e;
    if (i == 0) begin
      if (q0.size() == 0) begin
        check("sb_empty0", 1, 0);
        return;
      end
      e = q0[0];
      if (rr[0]) void'(q0.pop_front());
    end else begin
      if (q1.size() == 0) begin
        check("sb_empty1", 1, 0);
        return;
      end
      e = q1[0];
      if (rr[1]) void'(q1.pop_front());
    end
    check($sformatf("rsp_result%0d", i), rr_rsp_result[i*W +: W], e.res);
    check($sformatf("rsp_zero%0d", i), rr_zero[i], e.z);
    check($sformatf("rsp_greater%0d", i), rr_gt[i], e.g);
    check($sformatf("rsp_err%0d", i), rr_err[i], e.e);
  endtask

  task automatic step();
    logic [1:0] eg [2];
    logic [1:0] el;
    exp_t       x;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      el = rv & (~mv[k] | rr);
      if (reset)
        eg[k] = 2'b00;
      else if (el == 2'b11)
        eg[k] = (k == 1 || !mptr[k]) ? 2'b01 : 2'b10;
      else
        eg[k] = el;
    end
    check("rr_req_ready", rr_ready, eg[0]);
    check("fp_req_ready", fp_ready, eg[1]);
    if (started) begin
      check("rr_rsp_valid", rr_rsp_valid, mv[0]);
      check("fp_rsp_valid", fp_rsp_valid, mv[1]);
      for (int i = 0; i < 2; i++)
        if (mv[0][i]) chk_rsp(i);
    end
    if (eg[0] != 2'b00) begin
      x = eg[0][1] ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      check("alu_op", rr_alu_op, x.e ? 4'b0000 : (eg[0][1] ? op1 : op0));
      check("alu_a", rr_alu_a, eg[0][1] ? a1 : a0);
      if (eg[0][0]) q0.push_back(x);
      if (eg[0][1]) q1.push_back(x);
    end else begin
      check("alu_idle", {rr_alu_op, rr_alu_a}, '0);
    end
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mv[k]   = 2'b00;
        mptr[k] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++)
          if (eg[k][i]) mv[k][i] = 1'b1;
          else if (rr[i]) mv[k][i] = 1'b0;
        if (eg[k] != 2'b00) mptr[k] = eg[k][0];
      end
    end
    if (reset) begin
      q0.delete();
      q1.delete();
      started = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ops [7];

  initial begin
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b1100, 4'b0111, 4'b1111};
    mv[0] = 2'b00; mv[1] = 2'b00;
    mptr[0] = 1'b0; mptr[1] = 1'b0;
    reset = 1'b1;
    rv = 2'b00; rr = 2'b11;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    op0 = '0; op1 = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_result", rr_rsp_result[W-1:0], '0);
    check("rst_flags", {rr_zero, rr_gt, rr_err}, '0);

    // Basic add on requester 0
    rv = 2'b01; op0 = 4'b0010; a0 = 64'd5; b0 = 64'd7;
    step();
    check("t1_result", rr_rsp_result[W-1:0], 64'd12);
    rv = 2'b00;
    step();

    // Contention: round-robin alternates, fixed priority starves req1
    rv = 2'b11; rr = 2'b11;
    for (int n = 0; n < 8; n++) begin
      op0 = 4'b0010; op1 = 4'b0001;
      a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      step();
    end
    rv = 2'b10;
    step();
    rv = 2'b00;
    step();

    // Requester 0 boundary ops
    rv = 2'b01;
    op0 = 4'b0110; a0 = 64'd9; b0 = 64'd9;  step();
    op0 = 4'b0111; a0 = 64'd1; b0 = 64'd63; step();
    op0 = 4'b0010; a0 = 64'd3; b0 = 64'd2;  step();
    op0 = 4'b1100; a0 = '1;    b0 = '0;     step();
    rv = 2'b00;
    step();

    // Illegal op on requester 1
    rv = 2'b10; op1 = 4'b1111; a1 = 64'd4; b1 = 64'd1;
    step();
    rv = 2'b00;
    step();

    // Back-pressure, drain+refill, reset while holding
    rv = 2'b01; rr = 2'b10; op0 = 4'b0001; a0 = 64'hf0; b0 = 64'h0f;
    step(); step(); step();
    rr = 2'b11; a0 = 64'h100;
    step();
    rv = 2'b00;
    step(); step();
    rv = 2'b01; rr = 2'b10;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0; rv = 2'b00;
    step();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rv  = 2'($urandom);
      rr  = 2'($urandom);
      op0 = ops[$urandom_range(0, 6)];
      op1 = ops[$urandom_range(0, 6)];
      a0  = {$urandom, $urandom}; b0 = {$urandom, $urandom};
      a1  = {$urandom, $urandom}; b1 = 64'($urandom_range(0, 70));
      step();
    end
    rv = 2'b00; rr = 2'b11;
    step(); step();
    check("sb_drained", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
